// File: rtl/vga_pixel_sink.sv
// -----------------------------------------------------------------------------
// vga_pixel_sink
//
// Receiving end of the pixel-write stream produced by the drawing blocks.
// Incoming writes are buffered in a small FIFO. Each entry is range-checked
// when it is popped. In-range entries are turned into a linear framebuffer
// address (y*H_RES + x) and drive the single write port of the 160x120 video
// memory. The block can also fill the whole screen with one colour.
//
// Optional feature:
//   `define VGA_SINK_DROP_CNT_EN  adds a saturating 16-bit drop_count output.
//   The counter counts popped out-of-range pixels and writes discarded on
//   overflow. When the macro is not defined, the port and the counter are
//   absent.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   wr_en         in   pixel write request
//   wr_coords     in   {x[7:0], y[6:0]}
//   wr_colour     in   RGB 3:3:3 pixel colour
//   wr_ready      out  a write presented this cycle is accepted
//   clear_go      in   one-cycle request to fill the screen
//   clear_colour  in   fill colour, sampled together with clear_go
//   clear_done    out  one-cycle pulse after the last clear write
//   busy          out  FIFO non-empty, clear pending/active or write in flight
//   overflow      out  sticky: a write was presented while wr_ready was low
//   mem_we        out  framebuffer write strobe (registered)
//   mem_addr      out  framebuffer address (registered)
//   mem_data      out  framebuffer write data (registered)
//   drop_count    out  (VGA_SINK_DROP_CNT_EN only) saturating drop counter
// -----------------------------------------------------------------------------
module vga_pixel_sink #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned H_RES = 160,
    parameter int unsigned V_RES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [14:0] wr_coords,
    input  logic [8:0]  wr_colour,
    output logic        wr_ready,
    input  logic        clear_go,
    input  logic [8:0]  clear_colour,
    output logic        clear_done,
    output logic        busy,
    output logic        overflow,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [8:0]  mem_data
`ifdef VGA_SINK_DROP_CNT_EN
    ,
    output logic [15:0] drop_count
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [14:0] LAST_IDX = 15'(H_RES * V_RES - 1);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO. The pointers carry one extra wrap bit, so full and empty can be
    // told apart without a separate occupancy counter.
    // ------------------------------------------------------------------
    logic [23:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;

    state_t      state_q;
    logic        clear_pending_q;
    logic [8:0]  clear_colour_q;
    logic [14:0] clr_cnt_q;
    logic        mem_we_q;
    logic [14:0] mem_addr_q;
    logic [8:0]  mem_data_q;
    logic        clear_done_q;
    logic        overflow_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // wr_ready depends only on registered state. A pop therefore frees a slot
    // for the next cycle, not for the current one. There is no pass-through.
    assign wr_ready = !fifo_full && !clear_pending_q && (state_q != ST_CLEAR);
    assign push     = wr_en && wr_ready;
    assign pop      = (state_q == ST_IDLE) && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The storage has no reset. Only entries between the pointers are ever used.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {wr_coords, wr_colour};
        end
    end

    // ------------------------------------------------------------------
    // Head entry decode: range check and linear address.
    // ------------------------------------------------------------------
    logic [23:0] head;
    logic [7:0]  head_x;
    logic [6:0]  head_y;
    logic [8:0]  head_col;
    logic        head_in_range;
    logic [14:0] head_addr;

    assign head          = fifo_mem[rd_ptr_q[AW-1:0]];
    assign head_x        = head[23:16];
    assign head_y        = head[15:9];
    assign head_col      = head[8:0];
    assign head_in_range = (32'(head_x) < H_RES) && (32'(head_y) < V_RES);
    // Largest in-range result is H_RES*V_RES-1, so 15 bits are always enough.
    assign head_addr     = 15'(32'(head_y) * H_RES + 32'(head_x));

    // ------------------------------------------------------------------
    // Control FSM with registered memory-port outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            clear_pending_q <= 1'b0;
            clear_colour_q  <= '0;
            clr_cnt_q       <= '0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            clear_done_q    <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            clear_done_q <= 1'b0;

            // A clear request is taken once. Repeats are ignored until the
            // current clear has finished.
            if (clear_go && !clear_pending_q && (state_q != ST_CLEAR)) begin
                clear_pending_q <= 1'b1;
                clear_colour_q  <= clear_colour;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        // An out-of-range entry is consumed without a write.
                        mem_we_q <= head_in_range;
                        if (head_in_range) begin
                            mem_addr_q <= head_addr;
                            mem_data_q <= head_col;
                        end
                    end else if (clear_pending_q && fifo_empty) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= clr_cnt_q;
                    mem_data_q <= clear_colour_q;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 15'd1;
                    end
                end
                ST_DONE: begin
                    clear_done_q    <= 1'b1;
                    clear_pending_q <= 1'b0;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (wr_en && !wr_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;
    assign busy       = !fifo_empty || clear_pending_q || (state_q != ST_IDLE) || mem_we_q;

`ifdef VGA_SINK_DROP_CNT_EN
    // A popped out-of-range pixel and an overflow discard can occur in the
    // same cycle. Both are counted, so the step can be 2.
    logic [15:0] drop_cnt_q;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    assign drop_inc = {1'b0, pop && !head_in_range} + {1'b0, wr_en && !wr_ready};
    assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_sink
//
// Self-checking bench for vga_pixel_sink with the default parameters
// (DEPTH=8, 160x120). A scoreboard queue holds the framebuffer writes each
// pixel or clear should produce: address y*160+x, or the clear index. A
// negedge monitor compares every observed mem_we cycle against the queue.
// -----------------------------------------------------------------------------
module tb_vga_pixel_sink;

    localparam int LAST = 160 * 120 - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en;
    logic [14:0] wr_coords;
    logic [8:0]  wr_colour;
    logic        wr_ready;
    logic        clear_go;
    logic [8:0]  clear_colour;
    logic        clear_done;
    logic        busy;
    logic        overflow;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [8:0]  mem_data;
`ifdef VGA_SINK_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    vga_pixel_sink dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_coords    (wr_coords),
        .wr_colour    (wr_colour),
        .wr_ready     (wr_ready),
        .clear_go     (clear_go),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .busy         (busy),
        .overflow     (overflow),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data)
`ifdef VGA_SINK_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int exp_edge;
        bit is_clear;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   clear_done_cnt = 0;
    int   exp_drop = 0;
    bit   prev_we = 1'b0;
    int   prev_addr = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     tag, got, got, want, want, $time);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", int'(mem_addr), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mem_addr", int'(mem_addr), mon_e.addr);
                    check("mem_data", int'(mem_data), mon_e.data);
                    if (!mon_e.is_clear) begin
                        check("latency", edge_cnt, mon_e.exp_edge);
                    end else if (mon_e.addr != 0) begin
                        check("clear_consecutive", int'(prev_we), 1);
                    end
                end
            end
            if (clear_done) begin
                clear_done_cnt++;
                check("done_after_last", (prev_we && prev_addr == LAST) ? 1 : 0, 1);
            end
            prev_we   = mem_we;
            prev_addr = int'(mem_addr);
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pixel for one cycle. The stimulus only calls this when the
    // model says the sink must accept, so the model predicts wr_ready = 1.
    task automatic send(input int x, input int y, input int col);
        exp_t e;
        wr_en     = 1'b1;
        wr_coords = {x[7:0], y[6:0]};
        wr_colour = col[8:0];
        check("wr_ready_accept", int'(wr_ready), 1);
        if (x < 160 && y < 120) begin
            e.addr     = y * 160 + x;
            e.data     = col & 'h1FF;
            e.exp_edge = edge_cnt + 2;
            e.is_clear = 1'b0;
            exp_q.push_back(e);
        end else begin
            exp_drop++;
        end
        $display("pixel x=%0d y=%0d colour=%03h edge=%0d", x, y, col & 'h1FF, edge_cnt);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic queue_clear(input int col);
        exp_t e;
        for (int a = 0; a <= LAST; a++) begin
            e.addr     = a;
            e.data     = col;
            e.exp_edge = -1;
            e.is_clear = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        int x, y, n, done_before;
        wr_en        = 1'b0;
        wr_coords    = '0;
        wr_colour    = '0;
        clear_go     = 1'b0;
        clear_colour = '0;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_wr_ready", int'(wr_ready), 1);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_data", int'(mem_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_clear_done", int'(clear_done), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Single write: x=5, y=3 gives address 485
        send(5, 3, 'h1C0);
        wait_drain(20, "drain_single");
        check("busy_idle_single", int'(busy), 0);

        // Burst of 20 back-to-back unique pixels
        for (int i = 0; i < 20; i++) begin
            send((i * 7) % 160, i * 5, (i * 37 + 11) & 'h1FF);
        end
        wait_drain(40, "drain_burst");
        check("overflow_burst", int'(overflow), 0);

        // Out-of-range entries are consumed silently
        send(160, 0, 'h0FF);
        send(0, 120, 'h0F0);
        send(159, 119, 'h155);
        wait_drain(20, "drain_range");
`ifdef VGA_SINK_DROP_CNT_EN
        check("drop_count_range", int'(drop_count), exp_drop);
`endif

        // Randomized pixel traffic with gaps and some out-of-range coordinates
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                x = int'($urandom_range(0, 199));
                y = int'($urandom_range(0, 127));
                send(x, y, int'($urandom_range(0, 511)));
            end else begin
                tick();
            end
        end
        wait_drain(40, "drain_random");
        check("overflow_random", int'(overflow), 0);
        check("busy_idle_random", int'(busy), 0);

        // Three queued pixels, then a full-screen clear in black
        send(1, 1, 'h111);
        send(2, 2, 'h122);
        send(3, 3, 'h133);
        clear_go     = 1'b1;
        clear_colour = 9'h000;
        queue_clear(0);
        tick();
        clear_go = 1'b0;
        check("wr_ready_pending", int'(wr_ready), 0);
        check("busy_pending", int'(busy), 1);
        repeat (100) tick();
        // Hold a write request while the clear runs. It must be discarded.
        wr_en     = 1'b1;
        wr_coords = {8'd7, 7'd7};
        wr_colour = 9'h1FF;
        for (int i = 0; i < 50; i++) begin
            check("wr_ready_clear", int'(wr_ready), 0);
            exp_drop++;
            tick();
        end
        wr_en = 1'b0;
        check("overflow_clear", int'(overflow), 1);
        wait_drain(25000, "drain_clear");
        check("clear_done_count", clear_done_cnt, 1);
        check("overflow_sticky", int'(overflow), 1);
        check("wr_ready_after_clear", int'(wr_ready), 1);
        check("busy_after_clear", int'(busy), 0);
`ifdef VGA_SINK_DROP_CNT_EN
        check("drop_count_clear", int'(drop_count), exp_drop);
`endif

        // Reset in the middle of a clear, at index 1000
        clear_go     = 1'b1;
        clear_colour = 9'h0AB;
        queue_clear('h0AB);
        tick();
        clear_go = 1'b0;
        n = 0;
        while (!(mem_we && mem_addr == 15'd1000) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reach_index_1000", int'(mem_addr), 1000);
        done_before = clear_done_cnt;
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        exp_drop = 0;
        check("arst_mem_we", int'(mem_we), 0);
        check("arst_mem_addr", int'(mem_addr), 0);
        check("arst_mem_data", int'(mem_data), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_overflow", int'(overflow), 0);
        check("arst_clear_done", int'(clear_done), 0);
        check("arst_wr_ready", int'(wr_ready), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) tick();
        check("no_done_after_reset", clear_done_cnt, done_before);

        // A fresh write after reset completes normally
        send(10, 20, 'h03F);
        wait_drain(20, "drain_after_reset");
        check("overflow_after_reset", int'(overflow), 0);
        check("busy_after_reset", int'(busy), 0);
`ifdef VGA_SINK_DROP_CNT_EN
        check("drop_count_reset", int'(drop_count), exp_drop);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
